// File: rtl/park_flip_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : park_seq_pkg
// Brief    : Shared types and constants for the VDMA park-pointer flip sequencer.
// Revision : 1.0 - initial release
// ============================================================================
package park_seq_pkg;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_WRITE     = 3'd1,
        S_PLOT      = 3'd2,
        S_WAIT_DONE = 3'd3,
        S_ADVANCE   = 3'd4
    } state_t;

    localparam logic [31:0] VDMA_BASE   = 32'h44A0_0000;
    localparam logic [31:0] PARK_OFS    = 32'h0000_0028;
    localparam int          FRAME_SEL_W = 4;
    localparam int          WDOG_W      = 32;

endpackage
`default_nettype wire

// File: rtl/park_flip_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : park_flip_sequencer_if
// Brief    : Valid/ready register-write channel toward the VDMA control port.
// Revision : 1.0 - initial release
// ============================================================================
interface park_flip_sequencer_if;

    logic        wr_valid;
    logic        wr_ready;
    logic [31:0] wr_addr;
    logic [31:0] wr_data;

    modport master (output wr_valid, output wr_addr, output wr_data, input wr_ready);
    modport slave  (input wr_valid, input wr_addr, input wr_data, output wr_ready);

endinterface
`default_nettype wire

// File: rtl/park_flip_sequencer_watchdog.sv
`default_nettype none
// ============================================================================
// Module   : park_watchdog
// Brief    : Plot watchdog; expired rises on the TIMEOUT_CYC-th tick after start.
// Revision : 1.0 - initial release
// ============================================================================
module park_watchdog
#(
    parameter logic [31:0] TIMEOUT_CYC = 32'd1_000_000
)
(
    input  logic clk,
    input  logic resetn,
    input  logic start,
    input  logic tick,
    output logic expired
);
    import park_seq_pkg::*;

    logic [WDOG_W-1:0] r_count;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_count <= '0;
        end else if (start) begin
            r_count <= '0;
        end else if (tick) begin
            r_count <= r_count + 32'd1;
        end
    end

    // Current tick counts, so compare one ahead of the registered count.
    assign expired = tick && ((r_count + 32'd1) >= TIMEOUT_CYC);

endmodule
`default_nettype wire

// File: rtl/park_flip_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : park_flip_sequencer
// Brief    : Cycles VDMA park frames: write park pointer, strobe plotter, wait, advance.
//            Optional plot watchdog enabled by defining PARK_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module park_flip_sequencer
#(
    parameter logic [31:0] BASE_ADDR   = park_seq_pkg::VDMA_BASE,
    parameter logic [31:0] PARK_OFS    = park_seq_pkg::PARK_OFS,
    parameter int          NUM_FRAMES  = 2,
    parameter logic [31:0] TIMEOUT_CYC = 32'd1_000_000
)
(
    input  logic                                 clk,
    input  logic                                 resetn,
    input  logic                                 loop_en,
    input  logic                                 plot_done,
    output logic                                 plot_en,
    park_flip_sequencer_if.master                wr_if,
    output logic [park_seq_pkg::FRAME_SEL_W-1:0] frame_sel,
    output logic [15:0]                          flip_count,
    output logic                                 busy,
    output logic                                 timeout_err
);
    import park_seq_pkg::*;

    localparam logic [FRAME_SEL_W-1:0] c_LAST_FRAME = FRAME_SEL_W'(NUM_FRAMES - 1);
    localparam logic [31:0]            c_PARK_ADDR  = BASE_ADDR + PARK_OFS;

    state_t                 r_state;
    logic [FRAME_SEL_W-1:0] w_next_frame;

    assign w_next_frame = (frame_sel >= c_LAST_FRAME) ? '0 : frame_sel + 1'b1;

`ifdef PARK_TIMEOUT_EN
    logic r_timeout_err;
    logic w_wd_start;
    logic w_wd_tick;
    logic w_wd_expired;

    assign w_wd_start  = (r_state == S_PLOT) && loop_en;
    assign w_wd_tick   = (r_state == S_WAIT_DONE);
    assign timeout_err = r_timeout_err;

    park_watchdog #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_watchdog (
        .clk     (clk),
        .resetn  (resetn),
        .start   (w_wd_start),
        .tick    (w_wd_tick),
        .expired (w_wd_expired)
    );
`else
    logic w_unused_timeout;

    assign w_unused_timeout = ^TIMEOUT_CYC;
    assign timeout_err      = 1'b0;
`endif

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state        <= S_IDLE;
            plot_en        <= 1'b0;
            wr_if.wr_valid <= 1'b0;
            wr_if.wr_addr  <= '0;
            wr_if.wr_data  <= '0;
            frame_sel      <= '0;
            flip_count     <= '0;
            busy           <= 1'b0;
`ifdef PARK_TIMEOUT_EN
            r_timeout_err  <= 1'b0;
`endif
        end else begin
            plot_en <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (loop_en) begin
                        r_state        <= S_WRITE;
                        busy           <= 1'b1;
                        wr_if.wr_valid <= 1'b1;
                        wr_if.wr_addr  <= c_PARK_ADDR;
                        wr_if.wr_data  <= '0;
                        frame_sel      <= '0;
                        flip_count     <= '0;
`ifdef PARK_TIMEOUT_EN
                        r_timeout_err  <= 1'b0;
`endif
                    end
                end
                // Valid stays up regardless of loop_en until the write is accepted.
                S_WRITE: begin
                    if (wr_if.wr_ready) begin
                        wr_if.wr_valid <= 1'b0;
                        if (loop_en) begin
                            r_state <= S_PLOT;
                            plot_en <= 1'b1;
                        end else begin
                            r_state <= S_IDLE;
                            busy    <= 1'b0;
                        end
                    end
                end
                S_PLOT: begin
                    if (!loop_en) begin
                        r_state <= S_IDLE;
                        busy    <= 1'b0;
                    end else begin
                        r_state <= S_WAIT_DONE;
                    end
                end
                S_WAIT_DONE: begin
                    if (!loop_en) begin
                        r_state <= S_IDLE;
                        busy    <= 1'b0;
                    end else if (plot_done) begin
                        r_state <= S_ADVANCE;
                    end
`ifdef PARK_TIMEOUT_EN
                    else if (w_wd_expired) begin
                        r_state       <= S_ADVANCE;
                        r_timeout_err <= 1'b1;
                    end
`endif
                end
                S_ADVANCE: begin
                    if (!loop_en) begin
                        r_state <= S_IDLE;
                        busy    <= 1'b0;
                    end else begin
                        r_state        <= S_WRITE;
                        wr_if.wr_valid <= 1'b1;
                        wr_if.wr_addr  <= c_PARK_ADDR;
                        wr_if.wr_data  <= {{(32 - FRAME_SEL_W){1'b0}}, w_next_frame};
                        frame_sel      <= w_next_frame;
                        if (flip_count != 16'hFFFF) begin
                            flip_count <= flip_count + 16'd1;
                        end
                    end
                end
                default: begin
                    r_state        <= S_IDLE;
                    busy           <= 1'b0;
                    wr_if.wr_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_park_flip_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_park_flip_sequencer
// Brief    : Scoreboarded bench: two sequencers (2 and 3 frames) with directed scenarios.
// Revision : 1.0 - initial release
// ============================================================================
module tb_park_flip_sequencer;

    localparam logic [31:0] c_ADDR = 32'h44A0_0028;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic resetn2 = 1'b0, loop_en2 = 1'b0, plot_done2 = 1'b0;
    logic resetn3 = 1'b0, loop_en3 = 1'b0, plot_done3 = 1'b0;
    logic        plot_en2, busy2, timeout_err2, plot_en3, busy3, timeout_err3;
    logic [3:0]  frame_sel2, frame_sel3;
    logic [15:0] flip_count2, flip_count3;

    park_flip_sequencer_if if2 ();
    park_flip_sequencer_if if3 ();

    park_flip_sequencer #(.NUM_FRAMES(2)) dut2 (
        .clk(clk), .resetn(resetn2), .loop_en(loop_en2), .plot_done(plot_done2),
        .plot_en(plot_en2), .wr_if(if2.master), .frame_sel(frame_sel2),
        .flip_count(flip_count2), .busy(busy2), .timeout_err(timeout_err2)
    );

    park_flip_sequencer #(.NUM_FRAMES(3), .TIMEOUT_CYC(32'd10)) dut3 (
        .clk(clk), .resetn(resetn3), .loop_en(loop_en3), .plot_done(plot_done3),
        .plot_en(plot_en3), .wr_if(if3.master), .frame_sel(frame_sel3),
        .flip_count(flip_count3), .busy(busy3), .timeout_err(timeout_err3)
    );

    int n_checks = 0;
    int n_pass   = 0;
    logic [31:0] q2[$];
    logic [31:0] q3[$];
    logic pend[2] = '{1'b0, 1'b0};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: actual %0h required %0h", name, act, req);
    endtask

    // Scoreboard monitor: pops the expected park value on every accepted write
    // and requires plot_en exactly one cycle later when loop_en was high.
    task automatic mon(input int id, input logic v, input logic r, input logic [31:0] a,
                       input logic [31:0] d, input logic pe, input logic le);
        logic [31:0] e;
        if (pe || pend[id]) check($sformatf("plot_en_after_accept_dut%0d", id), 32'(pe), 32'(pend[id]));
        pend[id] = 1'b0;
        if (v && r) begin
            check($sformatf("wr_addr_dut%0d", id), a, c_ADDR);
            if ((id == 0 && q2.size() == 0) || (id == 1 && q3.size() == 0)) begin
                n_checks++;
                $display("FAIL wr_extra_dut%0d: actual write data %0h required no write", id, d);
            end else begin
                e = (id == 0) ? q2.pop_front() : q3.pop_front();
                check($sformatf("wr_data_dut%0d", id), d, e);
            end
            pend[id] = le;
        end
    endtask

    always @(negedge clk) begin
        if (!resetn2) pend[0] = 1'b0;
        else mon(0, if2.wr_valid, if2.wr_ready, if2.wr_addr, if2.wr_data, plot_en2, loop_en2);
        if (!resetn3) pend[1] = 1'b0;
        else mon(1, if3.wr_valid, if3.wr_ready, if3.wr_addr, if3.wr_data, plot_en3, loop_en3);
    end

    // Plotter model for the 2-frame unit: done pulse three cycles after plot_en.
    always begin
        @(negedge clk);
        if (plot_en2) begin
            repeat (3) @(posedge clk);
            #1 plot_done2 = 1'b1;
            @(posedge clk);
            #1 plot_done2 = 1'b0;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: actual still running required finished");
        $fatal(1);
    end

    initial begin
        if2.wr_ready = 1'b0;
        if3.wr_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_wr_valid", 32'(if2.wr_valid), 32'd0);
        check("rst_wr_addr", if2.wr_addr, 32'd0);
        check("rst_wr_data", if2.wr_data, 32'd0);
        check("rst_frame_sel", 32'(frame_sel2), 32'd0);
        check("rst_flip_count", 32'(flip_count2), 32'd0);
        check("rst_busy", 32'(busy2), 32'd0);
        check("rst_plot_en", 32'(plot_en2), 32'd0);
        check("rst_timeout_err", 32'(timeout_err3), 32'd0);
        resetn2 = 1'b1;
        resetn3 = 1'b1;

        // Free-running loop, 2 frames: parks 0,1,0,1 then a fifth write of 0.
        if2.wr_ready = 1'b1;
        q2.push_back(0); q2.push_back(1); q2.push_back(0); q2.push_back(1); q2.push_back(0);
        @(posedge clk); #1 loop_en2 = 1'b1;
        @(negedge clk); check("lat_valid_before", 32'(if2.wr_valid), 32'd0);
        @(negedge clk); check("lat_valid_after", 32'(if2.wr_valid), 32'd1);
        for (int i = 0; i < 300 && flip_count2 != 16'd4; i++) @(negedge clk);
        check("loop_flip_count_4", 32'(flip_count2), 32'd4);
        @(posedge clk); #1 loop_en2 = 1'b0;
        repeat (10) @(negedge clk);
        check("loop_flip_hold", 32'(flip_count2), 32'd4);
        check("loop_idle_busy", 32'(busy2), 32'd0);

        // Ready held low for 5 cycles: request stable for 6.
        if2.wr_ready = 1'b0;
        q2.push_back(0);
        @(posedge clk); #1 loop_en2 = 1'b1;
        @(posedge clk);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("stall_valid", 32'(if2.wr_valid), 32'd1);
            check("stall_addr", if2.wr_addr, c_ADDR);
            check("stall_data", if2.wr_data, 32'd0);
            @(posedge clk); #1;
            if (i == 4) if2.wr_ready = 1'b1;
            if (i == 5) loop_en2 = 1'b0;
        end
        repeat (8) @(negedge clk);
        check("stall_idle_busy", 32'(busy2), 32'd0);

        // loop_en drops while the write is pending: valid held, then idle, no plot.
        if2.wr_ready = 1'b0;
        q2.push_back(0);
        @(posedge clk); #1 loop_en2 = 1'b1;
        @(posedge clk); #1 loop_en2 = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("drop_valid_held", 32'(if2.wr_valid), 32'd1);
        end
        @(posedge clk); #1 if2.wr_ready = 1'b1;
        @(negedge clk); check("drop_valid_accept", 32'(if2.wr_valid), 32'd1);
        @(negedge clk);
        check("drop_valid_low", 32'(if2.wr_valid), 32'd0);
        check("drop_busy", 32'(busy2), 32'd0);
        check("drop_no_plot", 32'(plot_en2), 32'd0);
        repeat (8) @(negedge clk);

        // Asynchronous reset while waiting for the plotter.
        q2.push_back(0); q2.push_back(1);
        @(posedge clk); #1 loop_en2 = 1'b1;
        for (int i = 0; i < 100 && flip_count2 != 16'd1; i++) @(negedge clk);
        for (int i = 0; i < 100 && !plot_en2; i++) @(negedge clk);
        check("arst_plot_seen", 32'(plot_en2), 32'd1);
        @(posedge clk); #1;
        check("arst_pre_frame", 32'(frame_sel2), 32'd1);
        check("arst_pre_busy", 32'(busy2), 32'd1);
        #1 resetn2 = 1'b0;
        #1;
        check("arst_wr_valid", 32'(if2.wr_valid), 32'd0);
        check("arst_wr_addr", if2.wr_addr, 32'd0);
        check("arst_wr_data", if2.wr_data, 32'd0);
        check("arst_frame_sel", 32'(frame_sel2), 32'd0);
        check("arst_flip_count", 32'(flip_count2), 32'd0);
        check("arst_busy", 32'(busy2), 32'd0);
        check("arst_plot_en", 32'(plot_en2), 32'd0);
        check("arst_timeout_err", 32'(timeout_err2), 32'd0);
        @(posedge clk); #1 loop_en2 = 1'b0;
        resetn2 = 1'b1;
        repeat (6) @(negedge clk);

        // 3 frames with plot_done held high: parks 0,1,2,0, advance right after entry.
        if3.wr_ready = 1'b1;
        plot_done3 = 1'b1;
        q3.push_back(0); q3.push_back(1); q3.push_back(2); q3.push_back(0);
        @(posedge clk); #1 loop_en3 = 1'b1;
        for (int i = 0; i < 50 && !plot_en3; i++) @(negedge clk);
        check("nf3_plot_seen", 32'(plot_en3), 32'd1);
        @(negedge clk);
        @(negedge clk); check("nf3_flip_in_advance", 32'(flip_count3), 32'd0);
        @(negedge clk);
        check("nf3_flip_after_advance", 32'(flip_count3), 32'd1);
        check("nf3_frame_after_advance", 32'(frame_sel3), 32'd1);
        check("nf3_rewrite_valid", 32'(if3.wr_valid), 32'd1);
        for (int i = 0; i < 100 && flip_count3 != 16'd3; i++) @(negedge clk);
        check("nf3_flip_3", 32'(flip_count3), 32'd3);
        @(posedge clk); #1 loop_en3 = 1'b0;
        repeat (6) @(negedge clk);
        check("nf3_frame_wrap", 32'(frame_sel3), 32'd0);
        check("nf3_idle_busy", 32'(busy3), 32'd0);

        plot_done3 = 1'b0;
`ifdef PARK_TIMEOUT_EN
        // Plotter never answers: watchdog fires on the tenth WAIT_DONE cycle.
        q3.push_back(0); q3.push_back(1); q3.push_back(0);
        @(posedge clk); #1 loop_en3 = 1'b1;
        for (int i = 0; i < 50 && !plot_en3; i++) @(negedge clk);
        check("wd_plot_seen", 32'(plot_en3), 32'd1);
        repeat (10) @(negedge clk);
        check("wd_not_yet", 32'(timeout_err3), 32'd0);
        check("wd_busy_waiting", 32'(busy3), 32'd1);
        @(negedge clk);
        check("wd_timeout_set", 32'(timeout_err3), 32'd1);
        check("wd_frame_before", 32'(frame_sel3), 32'd0);
        @(negedge clk);
        check("wd_frame_advanced", 32'(frame_sel3), 32'd1);
        check("wd_rewrite_valid", 32'(if3.wr_valid), 32'd1);
        @(posedge clk); #1 loop_en3 = 1'b0;
        repeat (3) @(negedge clk);
        check("wd_sticky", 32'(timeout_err3), 32'd1);
        check("wd_idle_busy", 32'(busy3), 32'd0);
        @(posedge clk); #1 loop_en3 = 1'b1;
        @(posedge clk); #1 loop_en3 = 1'b0;
        @(negedge clk);
        check("wd_cleared_on_rise", 32'(timeout_err3), 32'd0);
        check("wd_flip_cleared", 32'(flip_count3), 32'd0);
        repeat (4) @(negedge clk);
`else
        // Without the watchdog the sequencer waits for plot_done indefinitely.
        q3.push_back(0);
        @(posedge clk); #1 loop_en3 = 1'b1;
        for (int i = 0; i < 50 && !plot_en3; i++) @(negedge clk);
        check("nowd_plot_seen", 32'(plot_en3), 32'd1);
        repeat (20) @(negedge clk);
        check("nowd_still_waiting", 32'(busy3), 32'd1);
        check("nowd_no_advance", 32'(flip_count3), 32'd0);
        check("nowd_timeout_tied", 32'(timeout_err3), 32'd0);
        @(posedge clk); #1 loop_en3 = 1'b0;
        repeat (3) @(negedge clk);
        check("nowd_idle_busy", 32'(busy3), 32'd0);
`endif

        check("sb_q2_drained", 32'(q2.size()), 32'd0);
        check("sb_q3_drained", 32'(q3.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/park_flip_sequencer.md
PARK_FLIP_SEQUENCER -- requirements
Module: park_flip_sequencer

Interface
REQ-001 The block SHALL have parameter BASE_ADDR, default 32'h44A00000, meaning VDMA register base.
REQ-002 The block SHALL have parameter PARK_OFS, default 32'h28, meaning park-pointer register offset.
REQ-003 The block SHALL have parameter NUM_FRAMES, default 2, range 2..16, meaning frame buffers cycled.
REQ-004 The block SHALL have parameter TIMEOUT_CYC, default 32'd1_000_000, meaning plot watchdog limit in clk cycles.
REQ-005 The block SHALL have port clk, input, 1 bit, meaning clock; all logic is rising-edge.
REQ-006 The block SHALL have port resetn, input, 1 bit, meaning reset, asynchronous, active-low.
REQ-007 The block SHALL have port loop_en, input, 1 bit, meaning run request, level.
REQ-008 The block SHALL have port plot_done, input, 1 bit, meaning plotter-finished pulse or level.
REQ-009 The block SHALL have port plot_en, output, 1 bit, meaning one-cycle plot start strobe.
REQ-010 The block SHALL have ports wr_valid (output, 1), wr_ready (input, 1), wr_addr (output, 32) and wr_data (output, 32), meaning register-write handshake.
REQ-011 The block SHALL have port frame_sel, output, 4 bits, meaning currently parked frame.
REQ-012 The block SHALL have ports flip_count (output, 16), busy (output, 1) and timeout_err (output, 1).

Function
REQ-013 The FSM SHALL have states IDLE, WRITE, PLOT, WAIT_DONE and ADVANCE.
REQ-014 IDLE SHALL go to WRITE when loop_en=1.
REQ-015 In WRITE, the block SHALL drive wr_valid=1, wr_addr=BASE_ADDR+PARK_OFS and wr_data={28'b0,frame_sel}.
REQ-016 wr_addr and wr_data SHALL be held stable until the cycle in which wr_valid and wr_ready are both 1, with no combinational path from wr_ready to wr_valid.
REQ-017 The handshake cycle SHALL go to PLOT, or to IDLE if loop_en=0 in that cycle.
REQ-018 Once wr_valid has been raised, it SHALL NOT drop before the handshake completes, even if loop_en falls.
REQ-019 PLOT SHALL assert plot_en for exactly one cycle, then go to WAIT_DONE.
REQ-020 WAIT_DONE SHALL go to ADVANCE on plot_done=1; a plot_done that is already high on WAIT_DONE entry SHALL count.
REQ-021 In ADVANCE, frame_sel SHALL become (frame_sel+1) mod NUM_FRAMES and flip_count SHALL increment, saturating at 16'hFFFF; the state then goes to WRITE if loop_en=1, else IDLE.
REQ-022 In PLOT, WAIT_DONE or ADVANCE, loop_en=0 SHALL force IDLE on the next cycle; frame_sel and flip_count SHALL hold.
REQ-023 busy SHALL be 1 in every state except IDLE.
REQ-024 The loop_en 0->1 transition in IDLE SHALL clear flip_count and timeout_err and set frame_sel=0.
REQ-025 Latency from loop_en rising to wr_valid SHALL be 1 cycle; from the write handshake to plot_en SHALL be 1 cycle.

Reset
REQ-026 Asserting resetn=0 SHALL immediately force IDLE, with plot_en=0, wr_valid=0, wr_addr=0, wr_data=0, frame_sel=0, flip_count=0, busy=0 and timeout_err=0.
REQ-027 Reset mid-handshake SHALL drop wr_valid; this is the only allowed violation of REQ-018.

Configuration
REQ-028 With PARK_TIMEOUT_EN defined, a 32-bit counter SHALL clear on WAIT_DONE entry; when it reaches TIMEOUT_CYC without plot_done, timeout_err SHALL set (sticky) and the state SHALL go to ADVANCE.
REQ-029 Without PARK_TIMEOUT_EN, there SHALL be no counter, timeout_err SHALL be tied 0, and WAIT_DONE SHALL wait indefinitely.

Structure
REQ-030 Package park_seq_pkg SHALL hold the state enum typedef, VDMA_BASE and PARK_OFS constants, and the frame_sel width.
REQ-031 The watchdog SHALL be sub-module park_watchdog (start, tick, expired), instantiated only under PARK_TIMEOUT_EN.

Verification
REQ-032 Bench SHALL cover: loop_en=1 with wr_ready always 1 and plot_done 3 cycles after plot_en -> writes of data 0,1,0,1 to addr 32'h44A00028; flip_count=4 after 4 plots.
REQ-033 Bench SHALL cover: wr_ready held 0 for 5 cycles -> wr_valid/addr/data stable for 6 cycles; plot_en exactly 1 cycle after acceptance.
REQ-034 Bench SHALL cover: loop_en dropped while wr_valid=1 and wr_ready=0 -> wr_valid held until ready, then IDLE with no plot_en.
REQ-035 Bench SHALL cover: NUM_FRAMES=3 -> frame_sel sequence 0,1,2,0; plot_done high on WAIT_DONE entry -> ADVANCE next cycle.
REQ-036 Bench SHALL cover: PARK_TIMEOUT_EN with TIMEOUT_CYC=10 and plot_done never asserted -> timeout_err=1 after 10 cycles, frame_sel advances; loop_en re-rise clears it.
REQ-037 Bench SHALL cover: resetn=0 pulsed in WAIT_DONE -> all outputs return to reset values asynchronously.
